mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory port between instruction fetch (requester A) and load/store (requester B).
//  Two-state FSM grants one requester at a time and latches its command.
//  Drives the memory-port mux select and returns read data plus a one-cycle done pulse.
//  Sits between the fetch/LSU stages and the unified memory.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  TIMEOUT  16  max SERVE cycles without memReady before abort (used only with ARB_TIMEOUT_EN); >=2
// PORTS
//  clk         in   1       clock; all state changes on rising edge
//  reset       in   1       synchronous, active-high reset
//  reqA        in   1       fetch request; held high until doneA
//  addrA       in   ADDR_W  fetch address
//  wdataA      in   DATA_W  fetch write data (normally unused)
//  weA         in   1       fetch write enable
//  reqB        in   1       load/store request; held high until doneB
//  addrB       in   ADDR_W  load/store address
//  wdataB      in   DATA_W  store data
//  weB         in   1       1=store, 0=load
//  doneA       out  1       one-cycle pulse: A transaction complete
//  doneB       out  1       one-cycle pulse: B transaction complete
//  rdata       out  DATA_W  read data of last completed transaction (registered)
//  select      out  1       memory-port mux select, 0=A, 1=B
//  busy        out  1       1 while in SERVE
//  memReq      out  1       memory request, registered
//  memAddr     out  ADDR_W  latched address
//  memWdata    out  DATA_W  latched write data
//  memWe       out  1       latched write enable
//  memReady    in   1       memory completes the transaction this cycle
//  memRdata    in   DATA_W  read data, valid when memReady=1
//  errTimeout  out  1       one-cycle abort pulse (tied 0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset values: all outputs 0. Internal lastOwner=1, so A wins the first tie.
//  States: IDLE, SERVE.
//  IDLE, on a sampled request:
//   - grant the requester; if both request, grant the one != lastOwner (round-robin)
//   - a requester whose done is high this cycle is excluded from arbitration
//   - on grant: latch addr/wdata/we, set select=owner, go to SERVE
//  SERVE: memReq=busy=1. Latched command is stable; later requester input changes are ignored.
//  SERVE, on memReady=1:
//   - rdata<=memRdata (loads and stores alike)
//   - pulse owner's done for one cycle; memReq=0; lastOwner<=owner
//   - return to IDLE
//  Latency: req sampled at edge 0 -> memReq high after edge 0 -> memReady seen at edge k -> done high after edge k.
//   - zero-wait memory: 2 cycles req-to-done
//   - at least one IDLE cycle between transactions
//  memReady in IDLE is ignored. select holds the last owner while in IDLE.
//  doneA and doneB are never high together.
//  Reset mid-SERVE: return to IDLE with all outputs 0 after the reset edge.
//   - transaction abandoned; no done pulse is emitted
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - counter cleared on grant; increments each SERVE cycle with memReady=0
//   - at count==TIMEOUT-1 with memReady=0: abort, i.e. memReq<=0, owner's done and errTimeout pulse together
//   - on abort: rdata unchanged, lastOwner updated, go to IDLE
//   - memReady on the abort cycle wins: normal completion
//  ARB_TIMEOUT_EN undefined: no counter; SERVE waits indefinitely; errTimeout constant 0.
// TESTING
//  1. Only reqA, addrA=0x100, weA=0; memReady high 2 cycles after memReq, memRdata=0xDEADBEEF
//     -> memAddr=0x100, select=0, doneA single pulse, rdata=0xDEADBEEF, busy drops.
//  2. reqA and reqB rise together after reset -> A served first, then B; repeat the tie
//     -> A then B again (alternation); doneA/doneB never overlap.
//  3. reqB store addrB=0x40, wdataB=0x12345678; change addrB to 0x44 after grant
//     -> memWe=1, memAddr=0x40, memWdata=0x12345678, select=1 throughout SERVE.
//  4. reset pulsed while busy=1 -> next cycle memReq=busy=doneA=doneB=0, select=0;
//     subsequent tie grants A.
//  5. ARB_TIMEOUT_EN, TIMEOUT=4, memReady held 0 -> memReq high exactly 4 cycles,
//     then doneA+errTimeout pulse; without macro memReq stays high 20+ cycles.
//  6. Zero-wait memory (memReady=1), reqA dropped on doneA -> exactly one memReq cycle,
//     no second grant.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the requester command buses, the completion handshakes and the
//   unified memory port that mem_port_arbiter sits between.
//   slave  modport: the arbiter (consumes requests and memReady/memRdata,
//                   drives done/rdata/select/busy/mem* and errTimeout)
//   master modport: the environment (fetch, LSU and memory side)
// Parameters: ADDR_W address width, DATA_W data width.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Requester A (instruction fetch)
    logic              reqA;
    logic [ADDR_W-1:0] addrA;
    logic [DATA_W-1:0] wdataA;
    logic              weA;
    // Requester B (load/store)
    logic              reqB;
    logic [ADDR_W-1:0] addrB;
    logic [DATA_W-1:0] wdataB;
    logic              weB;
    // Completion / status
    logic              doneA;
    logic              doneB;
    logic [DATA_W-1:0] rdata;
    logic              select;
    logic              busy;
    logic              errTimeout;
    // Memory port
    logic              memReq;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              memWe;
    logic              memReady;
    logic [DATA_W-1:0] memRdata;

    modport slave (
        input  reqA, addrA, wdataA, weA,
        input  reqB, addrB, wdataB, weB,
        input  memReady, memRdata,
        output doneA, doneB, rdata, select, busy, errTimeout,
        output memReq, memAddr, memWdata, memWe
    );

    modport master (
        output reqA, addrA, wdataA, weA,
        output reqB, addrB, wdataB, weB,
        output memReady, memRdata,
        input  doneA, doneB, rdata, select, busy, errTimeout,
        input  memReq, memAddr, memWdata, memWe
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (A) and load/store (B).
//   A two-state FSM (IDLE/SERVE) grants one requester at a time, latches its
//   command onto the memory port, and returns registered read data plus a
//   one-cycle done pulse to the owner. Ties are broken round-robin against
//   the last owner; A wins the first tie after reset.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-high
//   bus    : mem_port_arbiter_if.slave (requests, done/rdata, memory port)
// Parameters: ADDR_W, DATA_W, TIMEOUT (>=2, only used with ARB_TIMEOUT_EN).
// Optional feature: define ARB_TIMEOUT_EN to abort a SERVE that sees no
//   memReady for TIMEOUT cycles (pulses owner's done with errTimeout).
//   Without it SERVE waits indefinitely and errTimeout is tied 0.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;

    if (TIMEOUT < 2) begin : g_timeout_range
        $error("mem_port_arbiter: TIMEOUT must be >= 2");
    end

    logic [0:0] state;
    logic       last_owner;
    logic       elig_a;
    logic       elig_b;
    logic       grant_any;
    logic       grant_b;
    logic       finish;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             expire;
`endif

    // A requester whose done pulse is still high is finishing its previous
    // transaction and must not be re-granted on the same edge.
    always_comb begin
        elig_a    = bus.reqA & ~bus.doneA;
        elig_b    = bus.reqB & ~bus.doneB;
        grant_any = elig_a | elig_b;
        grant_b   = (elig_a & elig_b) ? ~last_owner : elig_b;
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        expire = ~bus.memReady & (wait_cnt == CNT_LAST);
        finish = (state == SERVE) & (bus.memReady | expire);
    end
`else
    always_comb begin
        finish = (state == SERVE) & bus.memReady;
    end
    assign bus.errTimeout = 1'b0;
`endif

    // select doubles as the owner register: it is only written on grant, so
    // it names the current owner in SERVE and the last owner in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_owner   <= 1'b1;
            bus.select   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.memReq   <= 1'b0;
            bus.memAddr  <= '0;
            bus.memWdata <= '0;
            bus.memWe    <= 1'b0;
            bus.rdata    <= '0;
            bus.doneA    <= 1'b0;
            bus.doneB    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bus.errTimeout <= 1'b0;
            wait_cnt       <= '0;
`endif
        end else begin
            bus.doneA <= 1'b0;
            bus.doneB <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            bus.errTimeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state        <= SERVE;
                        bus.select   <= grant_b;
                        bus.busy     <= 1'b1;
                        bus.memReq   <= 1'b1;
                        bus.memAddr  <= grant_b ? bus.addrB  : bus.addrA;
                        bus.memWdata <= grant_b ? bus.wdataB : bus.wdataA;
                        bus.memWe    <= grant_b ? bus.weB    : bus.weA;
`ifdef ARB_TIMEOUT_EN
                        wait_cnt     <= '0;
`endif
                    end
                end
                SERVE: begin
                    if (finish) begin
                        state      <= IDLE;
                        bus.busy   <= 1'b0;
                        bus.memReq <= 1'b0;
                        bus.doneA  <= ~bus.select;
                        bus.doneB  <= bus.select;
                        last_owner <= bus.select;
                        if (bus.memReady) begin
                            bus.rdata <= bus.memRdata;
                        end
`ifdef ARB_TIMEOUT_EN
                        else begin
                            bus.errTimeout <= 1'b1;
                        end
`endif
                    end
`ifdef ARB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios with literal expectations, followed by a randomized
//   phase. A transaction-level model tracks who owns the port, the latched
//   command and the expected completion, and every output is compared
//   against it on each falling edge.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic          m_busy;
    logic          m_owner;
    logic          m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we;
    logic [DW-1:0] m_rdata;
    logic          m_doneA;
    logic          m_doneB;
    logic          m_err;
    int            m_waited;

    // Who gets the port given who is asking; 0 = A, 1 = B.
    function automatic logic pick(input logic want_a, input logic want_b, input logic last);
        if (want_a && want_b) return !last;
        return want_b;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1;
            m_addr <= '0; m_wdata <= '0; m_we <= 1'b0; m_rdata <= '0;
            m_doneA <= 1'b0; m_doneB <= 1'b0; m_err <= 1'b0; m_waited <= 0;
        end else begin
            m_doneA <= 1'b0; m_doneB <= 1'b0; m_err <= 1'b0;
            if (!m_busy) begin
                if ((bus.reqA && !m_doneA) || (bus.reqB && !m_doneB)) begin
                    m_busy   <= 1'b1;
                    m_waited <= 0;
                    m_owner  <= pick(bus.reqA && !m_doneA, bus.reqB && !m_doneB, m_last);
                    if (pick(bus.reqA && !m_doneA, bus.reqB && !m_doneB, m_last)) begin
                        m_addr <= bus.addrB; m_wdata <= bus.wdataB; m_we <= bus.weB;
                    end else begin
                        m_addr <= bus.addrA; m_wdata <= bus.wdataA; m_we <= bus.weA;
                    end
                end
            end else if (bus.memReady) begin
                m_rdata <= bus.memRdata;
                m_busy  <= 1'b0;
                m_last  <= m_owner;
                if (m_owner) m_doneB <= 1'b1; else m_doneA <= 1'b1;
            end else begin
`ifdef ARB_TIMEOUT_EN
                if (m_waited + 1 == TO) begin
                    m_busy <= 1'b0;
                    m_last <= m_owner;
                    m_err  <= 1'b1;
                    if (m_owner) m_doneB <= 1'b1; else m_doneA <= 1'b1;
                end else begin
                    m_waited <= m_waited + 1;
                end
`else
                m_waited <= m_waited + 1;
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("doneA",      bus.doneA,      m_doneA);
            check("doneB",      bus.doneB,      m_doneB);
            check("rdata",      bus.rdata,      m_rdata);
            check("select",     bus.select,     m_owner);
            check("busy",       bus.busy,       m_busy);
            check("memReq",     bus.memReq,     m_busy);
            check("memAddr",    bus.memAddr,    m_addr);
            check("memWdata",   bus.memWdata,   m_wdata);
            check("memWe",      bus.memWe,      m_we);
            check("errTimeout", bus.errTimeout, m_err);
            check("done_excl",  bus.doneA & bus.doneB, 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b1;
        bus.reqA = 1'b0; bus.addrA = '0; bus.wdataA = '0; bus.weA = 1'b0;
        bus.reqB = 1'b0; bus.addrB = '0; bus.wdataB = '0; bus.weB = 1'b0;
        bus.memReady = 1'b0; bus.memRdata = '0;
        tick();
        tick();
        reset = 1'b0;
        cmp_en = 1'b1;
        check("reset_busy",   bus.busy,   1'b0);
        check("reset_memReq", bus.memReq, 1'b0);
        check("reset_select", bus.select, 1'b0);
        check("reset_rdata",  bus.rdata,  32'h0);

        // Single A load with two-cycle memory.
        bus.reqA = 1'b1; bus.addrA = 32'h100; bus.weA = 1'b0;
        tick();
        check("t1_memAddr", bus.memAddr, 32'h100);
        check("t1_select",  bus.select,  1'b0);
        check("t1_memReq",  bus.memReq,  1'b1);
        tick();
        check("t1_wait_done", bus.doneA, 1'b0);
        bus.memReady = 1'b1; bus.memRdata = 32'hDEADBEEF;
        tick();
        check("t1_doneA",       bus.doneA,  1'b1);
        check("t1_rdata",       bus.rdata,  32'hDEADBEEF);
        check("t1_model_rdata", m_rdata,    32'hDEADBEEF);
        check("t1_busy",        bus.busy,   1'b0);
        bus.reqA = 1'b0; bus.memReady = 1'b0;
        tick();
        check("t1_doneA_pulse", bus.doneA, 1'b0);

        // Tie after reset alternates A, B, then A again.
        do_reset();
        bus.memReady = 1'b1;
        bus.reqA = 1'b1; bus.addrA = 32'hA0;
        bus.reqB = 1'b1; bus.addrB = 32'hB0;
        tick();
        check("t2_first_A",   bus.select, 1'b0);
        check("t2_model_own", m_owner,    1'b0);
        tick();
        check("t2_doneA", bus.doneA, 1'b1);
        check("t2_doneB", bus.doneB, 1'b0);
        bus.reqA = 1'b0;
        tick();
        check("t2_then_B", bus.select, 1'b1);
        check("t2_busyB",  bus.busy,   1'b1);
        tick();
        check("t2_doneB2", bus.doneB, 1'b1);
        check("t2_doneA2", bus.doneA, 1'b0);
        bus.reqB = 1'b0;
        tick();
        bus.reqA = 1'b1; bus.reqB = 1'b1;
        tick();
        check("t2_second_tie_A", bus.select, 1'b0);
        tick();
        bus.reqA = 1'b0;
        tick();
        check("t2_second_B", bus.select, 1'b1);
        tick();
        bus.reqB = 1'b0; bus.memReady = 1'b0;
        tick();

        // B store; address change after grant is ignored.
        bus.reqB = 1'b1; bus.addrB = 32'h40; bus.wdataB = 32'h12345678; bus.weB = 1'b1;
        tick();
        bus.addrB = 32'h44;
        check("t3_memAddr", bus.memAddr, 32'h40);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_memAddr_hold",  bus.memAddr,  32'h40);
            check("t3_memWdata_hold", bus.memWdata, 32'h12345678);
            check("t3_memWe_hold",    bus.memWe,    1'b1);
            check("t3_select_hold",   bus.select,   1'b1);
        end
        bus.memReady = 1'b1; bus.memRdata = 32'h0BADF00D;
        tick();
        check("t3_doneB", bus.doneB, 1'b1);
        bus.reqB = 1'b0; bus.weB = 1'b0; bus.memReady = 1'b0;
        tick();

        // Reset while busy, then a tie grants A.
        bus.reqA = 1'b1; bus.addrA = 32'h200;
        bus.reqB = 1'b1; bus.addrB = 32'h300;
        tick();
        tick();
        check("t4_busy_before", bus.busy, 1'b1);
        do_reset();
        check("t4_memReq", bus.memReq, 1'b0);
        check("t4_busy",   bus.busy,   1'b0);
        check("t4_doneA",  bus.doneA,  1'b0);
        check("t4_doneB",  bus.doneB,  1'b0);
        check("t4_select", bus.select, 1'b0);
        tick();
        check("t4_tie_A",    bus.select,  1'b0);
        check("t4_tie_addr", bus.memAddr, 32'h200);
        bus.memReady = 1'b1;
        tick();
        bus.reqA = 1'b0;
        tick();
        tick();
        bus.reqB = 1'b0; bus.memReady = 1'b0;
        tick();

        // Zero-wait memory: one memReq cycle, no regrant.
        bus.memReady = 1'b1;
        bus.reqA = 1'b1; bus.addrA = 32'h500;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.memReq) n++;
            if (bus.doneA) bus.reqA = 1'b0;
        end
        check("t6_memReq_cycles", n, 1);
        bus.memReady = 1'b0;
        tick();

        // Stall: abort after TIMEOUT cycles, or wait indefinitely.
        bus.reqA = 1'b1; bus.addrA = 32'h600;
`ifdef ARB_TIMEOUT_EN
        tick();
        n = bus.memReq ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!bus.memReq) break;
            n++;
        end
        check("t5_memReq_cycles", n, TO);
        check("t5_doneA", bus.doneA,      1'b1);
        check("t5_err",   bus.errTimeout, 1'b1);
        bus.reqA = 1'b0;
        tick();
`else
        n = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.memReq) n++;
        end
        check("t5_memReq_cycles", n, 25);
        check("t5_no_err", bus.errTimeout, 1'b0);
        bus.memReady = 1'b1;
        tick();
        bus.reqA = 1'b0; bus.memReady = 1'b0;
        tick();
`endif

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            reset = ($urandom_range(0, 149) == 0);
            bus.memReady = ($urandom_range(0, 9) < 4);
            bus.memRdata = $urandom;
            if (bus.reqA && m_doneA) bus.reqA = ($urandom_range(0, 3) == 0);
            else if (!bus.reqA) bus.reqA = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.addrA = $urandom; bus.wdataA = $urandom; bus.weA = ($urandom_range(0, 7) == 0);
            end
            if (bus.reqB && m_doneB) bus.reqB = ($urandom_range(0, 3) == 0);
            else if (!bus.reqB) bus.reqB = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.addrB = $urandom; bus.wdataB = $urandom; bus.weB = $urandom_range(0, 1);
            end
        end
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
